ddr3_cpu_req_arbiter: RTL and testbench

Parametrised multi-port CPU front-end for the DDR3 memory controller. Accepts read/write requests from NUM_PORTS CPU ports and arbitrates them round-robin into one request FIFO. It presents a single valid/ready request stream to the controller core and routes read data returned by the core back to the requesting port, tracking outstanding reads per port. Sits between the CPU-side interfaces and the controller command scheduler.

---
 rtl/ddr3_ctrl_pkg.sv | 34 +++
 rtl/ddr3_req_fifo.sv | 67 ++++++
 rtl/ddr3_cpu_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_ddr3_cpu_req_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ctrl_pkg.sv
// Shared constants and helpers for the DDR3 controller CPU front-end.
package ddr3_ctrl_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int unsigned DEF_NUM_PORTS  = 2;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 64;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_MAX_RD_OUT = 4;

  // Upper bound on port count supported by the round-robin helper.
  localparam int unsigned MAX_PORTS = 32;

  // Returns the first requesting port at or after ptr, wrapping at num_ports.
  // Returns num_ports when nobody is requesting.
  function automatic int unsigned rr_next_grant(input logic [MAX_PORTS-1:0] req,
                                                input int unsigned          num_ports,
                                                input int unsigned          ptr);
    int unsigned pick;
    int unsigned idx;
    pick = num_ports;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < num_ports) begin
        idx = ptr + i;
        if (idx >= num_ports) idx = idx - num_ports;
        if (req[idx[4:0]] && (pick == num_ports)) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ddr3_req_fifo.sv
// Synchronous request FIFO; the head entry is read straight from storage registers.
module ddr3_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr3_cpu_req_arbiter.sv
// Multi-port CPU front-end: round-robin request arbitration into a FIFO, plus
// per-port outstanding-read tracking and read-data return routing.
module ddr3_cpu_req_arbiter
  import ddr3_ctrl_pkg::*;
#(
  parameter int unsigned  NUM_PORTS  = DEF_NUM_PORTS,
  parameter int unsigned  ADDR_W     = DEF_ADDR_W,
  parameter int unsigned  DATA_W     = DEF_DATA_W,
  parameter int unsigned  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned  MAX_RD_OUT = DEF_MAX_RD_OUT,
  localparam int unsigned PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned DM_W       = DATA_W / 8
) (
  input  logic                              CPU_CLK,
  input  logic                              RESET_N,
  input  logic [NUM_PORTS-1:0]              CMD,
  input  logic [NUM_PORTS-1:0]              ADDR_VALID,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  ADDR,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  WR_DATA,
  input  logic [NUM_PORTS-1:0][DM_W-1:0]    DM,
  output logic [NUM_PORTS-1:0]              REQ_READY,
  output logic [NUM_PORTS-1:0]              RD_DATA_RDY,
  output logic [NUM_PORTS-1:0]              RD_DATA_VALID,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  RD_DATA,
  output logic                              CTRL_REQ_VALID,
  input  logic                              CTRL_REQ_READY,
  output logic                              CTRL_CMD,
  output logic [ADDR_W-1:0]                 CTRL_ADDR,
  output logic [DATA_W-1:0]                 CTRL_WR_DATA,
  output logic [DM_W-1:0]                   CTRL_DM,
  output logic [PW-1:0]                     CTRL_PORT,
  input  logic                              CTRL_RD_VALID,
  input  logic [DATA_W-1:0]                 CTRL_RD_DATA,
  input  logic [PW-1:0]                     CTRL_RD_PORT,
  output logic                              PROTO_ERR
);

  localparam int unsigned CW      = $clog2(MAX_RD_OUT + 1);
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W + DM_W + PW;

  logic [PW-1:0]                    rr_q, rr_d;
  logic [NUM_PORTS-1:0][CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [NUM_PORTS-1:0]             rd_rdy_q, rd_rdy_d;
  logic [NUM_PORTS-1:0]             rd_vld_q, rd_vld_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
  logic                             perr_q, perr_d;

  logic [MAX_PORTS-1:0] elig_ext;
  int unsigned          grant_idx;
  logic                 grant_vld;
  logic [PW-1:0]        grant_port;
  logic                 accept;
  logic                 fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head, push_entry;
  logic                 rd_port_ok;

  // Eligibility and round-robin grant; a full FIFO masks every ready.
  always_comb begin
    elig_ext = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig_ext[p] = ADDR_VALID[p] & (CMD[p] | (rd_cnt_q[p] < CW'(MAX_RD_OUT)));
    end
    grant_idx  = rr_next_grant(elig_ext, NUM_PORTS, 32'(rr_q));
    grant_vld  = (grant_idx < NUM_PORTS);
    grant_port = grant_idx[PW-1:0];
    REQ_READY  = '0;
    if (grant_vld && !fifo_full) REQ_READY[grant_port] = 1'b1;
  end

  assign accept     = |REQ_READY;
  assign push_entry = {CMD[grant_port], ADDR[grant_port], WR_DATA[grant_port],
                       DM[grant_port], grant_port};

  // Priority moves past the port just accepted.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (32'(grant_port) == NUM_PORTS - 1) ? '0 : grant_port + PW'(1);
    end
  end

  ddr3_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (CPU_CLK),
    .rst_ni  (RESET_N),
    .push_i  (accept),
    .data_i  (push_entry),
    .pop_i   (CTRL_REQ_READY),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign CTRL_REQ_VALID = ~fifo_empty;
  assign {CTRL_CMD, CTRL_ADDR, CTRL_WR_DATA, CTRL_DM, CTRL_PORT} = fifo_head;

  assign rd_port_ok = (32'(CTRL_RD_PORT) < NUM_PORTS);

  // Read-return routing, outstanding-read counts and protocol-error detection.
  // An unexpected return is still delivered but leaves the count at zero.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_vld_d  = '0;
    rd_data_d = rd_data_q;
    perr_d    = perr_q;
    if (CTRL_RD_VALID) begin
      if (!rd_port_ok) begin
        perr_d = 1'b1;
      end else begin
        rd_vld_d[CTRL_RD_PORT]  = 1'b1;
        rd_data_d[CTRL_RD_PORT] = CTRL_RD_DATA;
        if (rd_cnt_q[CTRL_RD_PORT] == '0) begin
          perr_d = 1'b1;
        end else begin
          rd_cnt_d[CTRL_RD_PORT] = rd_cnt_q[CTRL_RD_PORT] - CW'(1);
        end
      end
    end
    if (accept && (CMD[grant_port] == CMD_READ)) begin
      rd_cnt_d[grant_port] = rd_cnt_d[grant_port] + CW'(1);
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_rdy_d[p] = (rd_cnt_q[p] != '0);
    end
  end

  assign RD_DATA_RDY   = rd_rdy_q;
  assign RD_DATA_VALID = rd_vld_q;
  assign RD_DATA       = rd_data_q;
  assign PROTO_ERR     = perr_q;

  // Arbiter and read-tracking state registers.
  always_ff @(posedge CPU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_q      <= '0;
      rd_cnt_q  <= '0;
      rd_rdy_q  <= '0;
      rd_vld_q  <= '0;
      rd_data_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_rdy_q  <= rd_rdy_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      perr_q    <= perr_d;
    end
  end

endmodule

// File: tb/tb_ddr3_cpu_req_arbiter.sv
// Self-checking bench for ddr3_cpu_req_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ddr3_cpu_req_arbiter;

  localparam int NP    = 2;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int MW    = DW / 8;
  localparam int PW    = 1;
  localparam int DEPTH = 4;
  localparam int MAXRD = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NP-1:0]           cmd, addr_valid;
  logic [NP-1:0][AW-1:0]   addr;
  logic [NP-1:0][DW-1:0]   wr_data;
  logic [NP-1:0][MW-1:0]   dm;
  logic [NP-1:0]           req_ready, rd_data_rdy, rd_data_valid;
  logic [NP-1:0][DW-1:0]   rd_data;
  logic                    ctrl_req_valid, ctrl_req_ready, ctrl_cmd;
  logic [AW-1:0]           ctrl_addr;
  logic [DW-1:0]           ctrl_wr_data;
  logic [MW-1:0]           ctrl_dm;
  logic [PW-1:0]           ctrl_port;
  logic                    ctrl_rd_valid;
  logic [DW-1:0]           ctrl_rd_data;
  logic [PW-1:0]           ctrl_rd_port;
  logic                    proto_err;

  ddr3_cpu_req_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .MAX_RD_OUT (MAXRD)
  ) dut (
    .CPU_CLK        (clk),
    .RESET_N        (rst_n),
    .CMD            (cmd),
    .ADDR_VALID     (addr_valid),
    .ADDR           (addr),
    .WR_DATA        (wr_data),
    .DM             (dm),
    .REQ_READY      (req_ready),
    .RD_DATA_RDY    (rd_data_rdy),
    .RD_DATA_VALID  (rd_data_valid),
    .RD_DATA        (rd_data),
    .CTRL_REQ_VALID (ctrl_req_valid),
    .CTRL_REQ_READY (ctrl_req_ready),
    .CTRL_CMD       (ctrl_cmd),
    .CTRL_ADDR      (ctrl_addr),
    .CTRL_WR_DATA   (ctrl_wr_data),
    .CTRL_DM        (ctrl_dm),
    .CTRL_PORT      (ctrl_port),
    .CTRL_RD_VALID  (ctrl_rd_valid),
    .CTRL_RD_DATA   (ctrl_rd_data),
    .CTRL_RD_PORT   (ctrl_rd_port),
    .PROTO_ERR      (proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: request queue, outstanding counts, priority pointer.
  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] dm;
    int            port;
  } req_t;

  req_t                  mq[$];
  int                    mcnt[NP];
  int                    mrr;
  bit                    mperr;
  logic [NP-1:0]         m_rdv, m_rdy;
  logic [NP-1:0][DW-1:0] m_rdd;
  int                    last_acc;

  function automatic int exp_grant();
    if (mq.size() >= DEPTH) return -1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (mrr + i) % NP;
      if (addr_valid[p] && (cmd[p] || mcnt[p] < MAXRD)) return p;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return '0;
    return NP'(1) << g;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int p = 0; p < NP; p++) mcnt[p] = 0;
    mrr = 0; mperr = 0; m_rdv = '0; m_rdy = '0; m_rdd = '0; last_acc = -1;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int   g;
    req_t e;
    g = exp_grant();
    last_acc = g;
    for (int p = 0; p < NP; p++) m_rdy[p] = (mcnt[p] != 0);
    m_rdv = '0;
    if (ctrl_req_ready && mq.size() > 0) void'(mq.pop_front());
    if (g >= 0) begin
      e.cmd = cmd[g]; e.addr = addr[g]; e.data = wr_data[g]; e.dm = dm[g]; e.port = g;
      mq.push_back(e);
      mrr = (g + 1) % NP;
    end
    if (ctrl_rd_valid) begin
      if (int'(ctrl_rd_port) >= NP) mperr = 1;
      else begin
        m_rdv[ctrl_rd_port] = 1'b1;
        m_rdd[ctrl_rd_port] = ctrl_rd_data;
        if (mcnt[ctrl_rd_port] == 0) mperr = 1;
        else mcnt[ctrl_rd_port]--;
      end
    end
    if (g >= 0 && cmd[g] == 1'b0) mcnt[g]++;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd = '0; addr_valid = '0; addr = '0; wr_data = '0; dm = '0;
    ctrl_req_ready = 1'b0; ctrl_rd_valid = 1'b0; ctrl_rd_data = '0; ctrl_rd_port = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (req_ready !== '0) begin n_fail++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_tests++; if (ctrl_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctrl_valid: got %b expected 0", ctrl_req_valid); end
    n_tests++; if ({ctrl_cmd, ctrl_addr, ctrl_wr_data, ctrl_dm, ctrl_port} !== '0) begin n_fail++;
      $display("FAIL reset_ctrl_fields: got addr %h data %h expected 0", ctrl_addr, ctrl_wr_data); end
    n_tests++; if (rd_data_valid !== '0 || rd_data !== '0) begin n_fail++;
      $display("FAIL reset_rd_data: got valid %b data %h expected 0", rd_data_valid, rd_data); end
    n_tests++; if (rd_data_rdy !== '0 || proto_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_rdy_err: got rdy %b err %b expected 0", rd_data_rdy, proto_err); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    apply_reset();
    ctrl_req_ready = 1'b1;
    cmd[0] = 1'b1; addr[0] = 32'h0000_1000; wr_data[0] = 64'hDEAD_BEEF_0123_4567;
    dm[0] = 8'hFF; addr_valid = 2'b01;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL single_req_ready: got %b expected 01", req_ready); end
    cyc();
    addr_valid = '0;
    n_tests++; if (ctrl_req_valid !== 1'b1 || ctrl_cmd !== 1'b1 || ctrl_port !== 1'b0) begin
      n_fail++;
      $display("FAIL single_head: got valid %b cmd %b port %0d expected 1 1 0",
               ctrl_req_valid, ctrl_cmd, ctrl_port); end
    n_tests++; if (ctrl_addr !== 32'h0000_1000 || ctrl_wr_data !== 64'hDEAD_BEEF_0123_4567 ||
                   ctrl_dm !== 8'hFF) begin n_fail++;
      $display("FAIL single_fields: got %h %h %h expected 00001000 deadbeef01234567 ff",
               ctrl_addr, ctrl_wr_data, ctrl_dm); end
    cyc();
    n_tests++; if (ctrl_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_pop: got valid %b expected 0", ctrl_req_valid); end
  endtask

  task automatic test_alternate();
    logic [NP-1:0] exp_rr;
    apply_reset();
    ctrl_req_ready = 1'b1;
    cmd = 2'b11; addr_valid = 2'b11;
    for (int p = 0; p < NP; p++) begin addr[p] = $urandom; wr_data[p] = {$urandom, $urandom}; end
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rr = NP'(1) << (k % 2);
      n_tests++; if (req_ready !== exp_rr) begin n_fail++;
        $display("FAIL alternate_grant%0d: got %b expected %b", k, req_ready, exp_rr); end
      cyc();
    end
    addr_valid = '0;
    repeat (3) cyc();
  endtask

  task automatic test_fifo_full();
    int n_acc;
    apply_reset();
    ctrl_req_ready = 1'b0;
    cmd = 2'b11; addr_valid = 2'b11;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (|req_ready) n_acc++;
      cyc();
    end
    n_tests++; if (n_acc != DEPTH) begin n_fail++;
      $display("FAIL full_accepts: got %0d expected %0d", n_acc, DEPTH); end
    #1;
    n_tests++; if (req_ready !== '0 || ctrl_req_valid !== 1'b1) begin n_fail++;
      $display("FAIL full_blocked: got ready %b valid %b expected 00 1", req_ready, ctrl_req_valid); end
    ctrl_req_ready = 1'b1;
    #1;
    n_tests++; if (req_ready !== '0) begin n_fail++;
      $display("FAIL full_pop_same_cycle: got %b expected 00", req_ready); end
    cyc();
    ctrl_req_ready = 1'b0;
    #1;
    n_tests++; if ($countones(req_ready) != 1) begin n_fail++;
      $display("FAIL full_resume: got %b expected one-hot", req_ready); end
    cyc();
    n_tests++; if (req_ready !== '0) begin n_fail++;
      $display("FAIL full_again: got %b expected 00", req_ready); end
    addr_valid = '0; ctrl_req_ready = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic test_read_limit();
    int n_acc;
    apply_reset();
    ctrl_req_ready = 1'b1;
    cmd = 2'b00; addr_valid = 2'b10; addr[1] = 32'h0000_2000;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready[1]) n_acc++;
      cyc();
    end
    n_tests++; if (n_acc != MAXRD) begin n_fail++;
      $display("FAIL rdlim_accepts: got %0d expected %0d", n_acc, MAXRD); end
    n_tests++; if (req_ready[1] !== 1'b0 || rd_data_rdy[1] !== 1'b1) begin n_fail++;
      $display("FAIL rdlim_block: got ready %b rdy %b expected 0 1", req_ready[1], rd_data_rdy[1]); end
    cmd[1] = 1'b1;
    #1;
    n_tests++; if (req_ready[1] !== 1'b1) begin n_fail++;
      $display("FAIL rdlim_write_ok: got %b expected 1", req_ready[1]); end
    cyc();
    cmd[1] = 1'b0;
    ctrl_rd_valid = 1'b1; ctrl_rd_port = 1'b1; ctrl_rd_data = 64'hA5A5_A5A5_A5A5_A5A5;
    #1;
    n_tests++; if (req_ready[1] !== 1'b0) begin n_fail++;
      $display("FAIL rdlim_still_block: got %b expected 0", req_ready[1]); end
    cyc();
    ctrl_rd_valid = 1'b0;
    n_tests++; if (rd_data_valid !== 2'b10 || rd_data[1] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_fail++;
      $display("FAIL rdlim_return: got valid %b data %h expected 10 a5a5a5a5a5a5a5a5",
               rd_data_valid, rd_data[1]); end
    n_tests++; if (req_ready[1] !== 1'b1) begin n_fail++;
      $display("FAIL rdlim_unblock: got %b expected 1", req_ready[1]); end
    cyc();
    addr_valid = '0;
    n_tests++; if (rd_data_valid !== '0 || rd_data[1] !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_fail++;
      $display("FAIL rdlim_strobe_len: got valid %b data %h expected 00 held", rd_data_valid,
               rd_data[1]); end
    repeat (3) cyc();
  endtask

  task automatic test_proto_err();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    n_tests++; if (proto_err !== 1'b0) begin n_fail++;
      $display("FAIL perr_before: got %b expected 0", proto_err); end
    ctrl_rd_valid = 1'b1; ctrl_rd_port = 1'b0; ctrl_rd_data = d;
    cyc();
    ctrl_rd_valid = 1'b0;
    n_tests++; if (rd_data_valid[0] !== 1'b1 || rd_data[0] !== d || proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_set: got valid %b data %h err %b expected 1 %h 1", rd_data_valid[0],
               rd_data[0], proto_err, d); end
    repeat (3) cyc();
    n_tests++; if (proto_err !== 1'b1 || rd_data_rdy[0] !== 1'b0) begin n_fail++;
      $display("FAIL perr_sticky: got err %b rdy %b expected 1 0", proto_err, rd_data_rdy[0]); end
  endtask

  task automatic test_random();
    int            p;
    logic [NP-1:0] er;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      n_tests++; if (ctrl_req_valid !== (mq.size() > 0)) begin n_fail++;
        $display("FAIL rand_ctrl_valid@%0d: got %b expected %b", k, ctrl_req_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_tests++;
        if (ctrl_cmd !== mq[0].cmd || ctrl_addr !== mq[0].addr || ctrl_wr_data !== mq[0].data ||
            ctrl_dm !== mq[0].dm || ctrl_port !== PW'(mq[0].port)) begin n_fail++;
          $display("FAIL rand_head@%0d: got %b %h %h %h %0d expected %b %h %h %h %0d", k,
                   ctrl_cmd, ctrl_addr, ctrl_wr_data, ctrl_dm, ctrl_port, mq[0].cmd,
                   mq[0].addr, mq[0].data, mq[0].dm, mq[0].port); end
      end
      n_tests++; if (rd_data_valid !== m_rdv || rd_data !== m_rdd) begin n_fail++;
        $display("FAIL rand_rd_data@%0d: got %b %h expected %b %h", k, rd_data_valid, rd_data,
                 m_rdv, m_rdd); end
      n_tests++; if (rd_data_rdy !== m_rdy || proto_err !== mperr) begin n_fail++;
        $display("FAIL rand_rdy_err@%0d: got %b %b expected %b %b", k, rd_data_rdy, proto_err,
                 m_rdy, mperr); end
      for (int q = 0; q < NP; q++) begin
        if (addr_valid[q] && last_acc != q) begin
          if ($urandom_range(9) == 0) addr_valid[q] = 1'b0;
        end else if ($urandom_range(9) < 6) begin
          addr_valid[q] = 1'b1; cmd[q] = $urandom_range(1); addr[q] = $urandom;
          wr_data[q] = {$urandom, $urandom}; dm[q] = MW'($urandom);
        end else begin
          addr_valid[q] = 1'b0;
        end
      end
      ctrl_req_ready = ($urandom_range(3) != 0);
      p = $urandom_range(NP - 1);
      ctrl_rd_valid = ($urandom_range(9) < 4) && (mcnt[p] > 0);
      ctrl_rd_port = PW'(p);
      ctrl_rd_data = {$urandom, $urandom};
      #1;
      er = exp_ready();
      n_tests++; if (req_ready !== er) begin n_fail++;
        $display("FAIL rand_req_ready@%0d: got %b expected %b", k, req_ready, er); end
      cyc();
    end
    idle_inputs();
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ctrl_req_ready = 1'b0;
    cmd = 2'b00; addr_valid = 2'b01;
    repeat (3) cyc();
    cmd[0] = 1'b1;
    cyc();
    addr_valid = '0;
    cyc();
    n_tests++; if (ctrl_req_valid !== 1'b1 || rd_data_rdy[0] !== 1'b1) begin n_fail++;
      $display("FAIL midrst_pre: got valid %b rdy %b expected 1 1", ctrl_req_valid, rd_data_rdy[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ctrl_req_valid !== 1'b0 || ctrl_addr !== '0 || ctrl_port !== '0 ||
                   rd_data_rdy !== '0 || req_ready !== '0 || proto_err !== 1'b0) begin n_fail++;
      $display("FAIL midrst_clear: got valid %b addr %h rdy %b ready %b expected all 0",
               ctrl_req_valid, ctrl_addr, rd_data_rdy, req_ready); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cmd = 2'b11; addr_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
    cyc();
    addr_valid = '0; ctrl_req_ready = 1'b1;
    repeat (3) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_alternate();
    test_fifo_full();
    test_read_limit();
    test_proto_err();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
